ft601_bus_responder: RTL and testbench

- Synthesizable model of the FT601 chip side of the 245 synchronous FIFO bus. It is the responder opposite the FPGA-side FIFO master.
- A host-side stream loads command words. The block presents them to the master through rxf_n, oe_n and rd_n.
- Words the master strobes with wr_n are captured into a buffer, which the host side drains.
- Used in the loopback and emulation builds, and as the bus partner in system benches.

---
 rtl/ft601_pkg.sv | 15 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/ft601_bus_responder.sv | 146 ++++++++++++++
 tb/tb_ft601_bus_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft601_pkg.sv
// rtl/ft601_pkg.sv - shared constants for the FT601 bus responder
package ft601_pkg;

  // Default bus geometry; BE is one enable bit per data byte.
  localparam int DEF_DATA_LEN = 32;
  localparam int DEF_BE_LEN   = DEF_DATA_LEN / 8;

  // Well-known command words used by loopback and emulation builds.
  localparam logic [DEF_DATA_LEN-1:0] CMD_START = 32'h11111111;
  localparam logic [DEF_DATA_LEN-1:0] CMD_STOP  = 32'h00000000;

  // Every byte lane enabled.
  localparam logic [DEF_BE_LEN-1:0] BE_ALL = '1;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with first-word-through head
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // Pops on an empty buffer and pushes into a full one are ignored; a push
  // alongside a pop is allowed when full since a slot frees up that edge.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Pointers and occupancy; clearing these empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while the count says empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/ft601_bus_responder.sv
// rtl/ft601_bus_responder.sv - FT601 chip side of the 245 synchronous FIFO bus
module ft601_bus_responder
  import ft601_pkg::*;
#(
  parameter int DATA_LEN = DEF_DATA_LEN,
  parameter int BE_LEN   = DEF_BE_LEN,
  parameter int CMD_AW   = 4,
  parameter int CAP_AW   = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_n,
  input  logic                rd_n,
  input  logic                oe_n,
  input  logic [DATA_LEN-1:0] bus_din,
  input  logic [BE_LEN-1:0]   be_din,
  output logic                txe_n,
  output logic                rxf_n,
  output logic [DATA_LEN-1:0] bus_dout,
  output logic [BE_LEN-1:0]   be_dout,
  output logic                bus_oe,
  input  logic                cmd_valid,
  input  logic [DATA_LEN-1:0] cmd_data,
  output logic                cmd_ready,
  output logic                cap_valid,
  output logic [DATA_LEN-1:0] cap_data,
  output logic [BE_LEN-1:0]   cap_be,
  input  logic                cap_ready,
  output logic                err_overflow,
  output logic                err_underrun,
  output logic                err_contention
);

  localparam logic [CAP_AW:0] CAP_FULL = (CAP_AW+1)'(1 << CAP_AW);

  logic                       cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic [DATA_LEN-1:0]        cmd_head;
  logic [CMD_AW:0]            cmd_count, cmd_count_d;
  logic                       cap_push, cap_pop, cap_full, cap_empty;
  logic [DATA_LEN+BE_LEN-1:0] cap_head;
  logic [CAP_AW:0]            cap_count, cap_count_d;

  logic                txe_n_q, txe_n_d;
  logic                rxf_n_q, rxf_n_d;
  logic                bus_oe_q, bus_oe_d;
  logic                pending_q, pending_d;
  logic [DATA_LEN-1:0] bus_dout_q, bus_dout_d;
  logic [BE_LEN-1:0]   be_dout_q, be_dout_d;
  logic                err_overflow_q, err_overflow_d;
  logic                err_underrun_q, err_underrun_d;
  logic                err_contention_q, err_contention_d;

  sync_fifo #(.W(DATA_LEN), .AW(CMD_AW)) u_cmd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_push),
    .push_data (cmd_data),
    .pop       (cmd_pop),
    .head      (cmd_head),
    .full      (cmd_full),
    .empty     (cmd_empty),
    .count     (cmd_count)
  );

  sync_fifo #(.W(DATA_LEN+BE_LEN), .AW(CAP_AW)) u_cap_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cap_push),
    .push_data ({be_din, bus_din}),
    .pop       (cap_pop),
    .head      (cap_head),
    .full      (cap_full),
    .empty     (cap_empty),
    .count     (cap_count)
  );

  // Buffer handshakes, plus next-edge occupancy so the flags never lag a push.
  always_comb begin
    cmd_push    = cmd_valid && !cmd_full;
    cmd_pop     = !rd_n && !rxf_n_q && !cmd_empty;
    cap_push    = !wr_n && !txe_n_q && oe_n && !cap_full;
    cap_pop     = cap_ready && !cap_empty;
    cmd_count_d = cmd_count + (CMD_AW+1)'(cmd_push) - (CMD_AW+1)'(cmd_pop);
    cap_count_d = cap_count + (CAP_AW+1)'(cap_push) - (CAP_AW+1)'(cap_pop);
  end

  // Bus-facing next state: rxf_n and the data word hold while rd_n is low so
  // the master sees a stable popped word until it releases the strobe.
  always_comb begin
    txe_n_d          = (cap_count_d == CAP_FULL);
    rxf_n_d          = rd_n ? (cmd_count_d == '0) : rxf_n_q;
    bus_oe_d         = !oe_n;
    pending_d        = pending_q;
    bus_dout_d       = bus_dout_q;
    be_dout_d        = be_dout_q;
    if (cmd_pop) begin
      pending_d = 1'b1;
    end else if (rd_n) begin
      pending_d  = 1'b0;
      bus_dout_d = cmd_empty ? '0 : cmd_head;
      be_dout_d  = cmd_empty ? '0 : '1;
    end
    err_overflow_d   = err_overflow_q   || (!wr_n && txe_n_q);
    err_underrun_d   = err_underrun_q   || (!rd_n && rxf_n_q);
    err_contention_d = err_contention_q || (!wr_n && !oe_n);
  end

  // Registered bus outputs and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txe_n_q          <= 1'b1;
      rxf_n_q          <= 1'b1;
      bus_oe_q         <= 1'b0;
      pending_q        <= 1'b0;
      bus_dout_q       <= '0;
      be_dout_q        <= '0;
      err_overflow_q   <= 1'b0;
      err_underrun_q   <= 1'b0;
      err_contention_q <= 1'b0;
    end else begin
      txe_n_q          <= txe_n_d;
      rxf_n_q          <= rxf_n_d;
      bus_oe_q         <= bus_oe_d;
      pending_q        <= pending_d;
      bus_dout_q       <= bus_dout_d;
      be_dout_q        <= be_dout_d;
      err_overflow_q   <= err_overflow_d;
      err_underrun_q   <= err_underrun_d;
      err_contention_q <= err_contention_d;
    end
  end

  assign txe_n          = txe_n_q;
  assign rxf_n          = rxf_n_q;
  assign bus_oe         = bus_oe_q;
  assign bus_dout       = bus_dout_q;
  assign be_dout        = be_dout_q;
  assign cmd_ready      = !cmd_full;
  assign cap_valid      = !cap_empty;
  assign cap_data       = cap_head[DATA_LEN-1:0];
  assign cap_be         = cap_head[DATA_LEN +: BE_LEN];
  assign err_overflow   = err_overflow_q;
  assign err_underrun   = err_underrun_q;
  assign err_contention = err_contention_q;

endmodule

// File: tb/tb_ft601_bus_responder.sv
// tb/tb_ft601_bus_responder.sv - scoreboard bench for the FT601 bus responder
module tb_ft601_bus_responder;
  import ft601_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_n, rd_n, oe_n;
  logic [31:0] bus_din, bus_dout, cmd_data, cap_data;
  logic [3:0]  be_din, be_dout, cap_be;
  logic        txe_n, rxf_n, bus_oe;
  logic        cmd_valid, cmd_ready, cap_valid, cap_ready;
  logic        err_overflow, err_underrun, err_contention;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cap_pops = 0;
  int          pops_base;
  logic        rd_pend  = 1'b0;
  logic [31:0] exp_rd[$];
  logic [35:0] exp_cap[$];
  logic [31:0] w;
  logic [31:0] e_rd;
  logic [35:0] e_cap;

  ft601_bus_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_n           (wr_n),
    .rd_n           (rd_n),
    .oe_n           (oe_n),
    .bus_din        (bus_din),
    .be_din         (be_din),
    .txe_n          (txe_n),
    .rxf_n          (rxf_n),
    .bus_dout       (bus_dout),
    .be_dout        (be_dout),
    .bus_oe         (bus_oe),
    .cmd_valid      (cmd_valid),
    .cmd_data       (cmd_data),
    .cmd_ready      (cmd_ready),
    .cap_valid      (cap_valid),
    .cap_data       (cap_data),
    .cap_be         (cap_be),
    .cap_ready      (cap_ready),
    .err_overflow   (err_overflow),
    .err_underrun   (err_underrun),
    .err_contention (err_contention)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_cmd(input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Master read: prep cycle with oe_n low, one-cycle rd_n strobe, release.
  task automatic read_word(input logic [31:0] d);
    exp_rd.push_back(d);
    oe_n = 1'b0;
    tick();
    rd_n = 1'b0;
    tick();
    chk("dout_hold_strobe", bus_dout, d);
    rd_n = 1'b1;
    tick();
  endtask

  task automatic write_word(input logic [31:0] d, input logic [3:0] be);
    exp_cap.push_back({be, d});
    wr_n    = 1'b0;
    bus_din = d;
    be_din  = be;
    tick();
    wr_n = 1'b1;
    tick();
    tick();
  endtask

  // Monitor: master captures the popped word on the negedge after its strobe;
  // host-side captured words are checked whenever they are consumed.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_rd.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected: got %0h expected none", bus_dout);
      end else begin
        e_rd = exp_rd.pop_front();
        chk("rd_word", {be_dout, bus_dout}, {BE_ALL, e_rd});
      end
    end
    rd_pend = rst_n && !rd_n && !rxf_n;
    if (rst_n && cap_valid && cap_ready) begin
      cap_pops++;
      if (exp_cap.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL cap_unexpected: got %0h expected none", {cap_be, cap_data});
      end else begin
        e_cap = exp_cap.pop_front();
        chk("cap_word", {cap_be, cap_data}, e_cap);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; wr_n = 1'b1; rd_n = 1'b1; oe_n = 1'b1;
    bus_din = '0; be_din = '0; cmd_valid = 1'b0; cmd_data = '0; cap_ready = 1'b0;

    // Reset values, sampled mid-clock while held in reset.
    repeat (2) @(posedge clk);
    #3;
    chk("rst_txe_n", txe_n, 1);
    chk("rst_rxf_n", rxf_n, 1);
    chk("rst_bus_oe", bus_oe, 0);
    chk("rst_cap_valid", cap_valid, 0);
    chk("rst_bus_dout", bus_dout, 0);
    chk("rst_errs", {err_overflow, err_underrun, err_contention}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("rel_txe_n", txe_n, 0);
    chk("rel_rxf_n", rxf_n, 1);
    chk("rel_cmd_ready", cmd_ready, 1);

    // Single command read, last word in buffer.
    load_cmd(CMD_START);
    tick();
    chk("cmd_rxf_loaded", rxf_n, 0);
    chk("cmd_dout_head", bus_dout, CMD_START);
    exp_rd.push_back(CMD_START);
    oe_n = 1'b0;
    tick();
    chk("cmd_bus_oe", bus_oe, 1);
    rd_n = 1'b0;
    tick();
    chk("cmd_rxf_strobe", rxf_n, 0);
    chk("cmd_dout_strobe", bus_dout, CMD_START);
    rd_n = 1'b1;
    tick();
    chk("cmd_rxf_after", rxf_n, 1);
    chk("cmd_be_empty", be_dout, 0);
    chk("cmd_dout_empty", bus_dout, 0);
    oe_n = 1'b1;
    tick();
    chk("cmd_bus_oe_off", bus_oe, 0);

    // Two commands read back to back.
    load_cmd(CMD_START);
    load_cmd(CMD_STOP);
    tick();
    read_word(CMD_START);
    chk("b2b_dout_next", bus_dout, CMD_STOP);
    chk("b2b_rxf_mid", rxf_n, 0);
    read_word(CMD_STOP);
    chk("b2b_rxf_end", rxf_n, 1);
    oe_n = 1'b1;
    tick();

    // Capture path with host draining.
    cap_ready = 1'b1;
    for (int i = 1; i <= 3; i++) write_word(32'hA5A5_0000 + 32'(i), 4'hF);
    chk("cap_errs", {err_overflow, err_underrun, err_contention}, 0);
    chk("cap_drained", exp_cap.size(), 0);

    // Overflow: 65 back-to-back writes with host stalled.
    cap_ready = 1'b0;
    for (int i = 0; i < 65; i++) begin
      w = 32'hC0DE_0000 + 32'(i);
      if (i < 64) exp_cap.push_back({4'hF, w});
      wr_n = 1'b0; bus_din = w; be_din = 4'hF;
      tick();
      if (i == 62) chk("ovf_txe_63", txe_n, 0);
      if (i == 63) begin
        chk("ovf_txe_64", txe_n, 1);
        chk("ovf_err_64", err_overflow, 0);
      end
    end
    wr_n = 1'b1;
    tick();
    chk("ovf_err", err_overflow, 1);
    chk("ovf_txe_hold", txe_n, 1);
    pops_base = cap_pops;
    cap_ready = 1'b1;
    repeat (70) tick();
    chk("ovf_cap_count", cap_pops - pops_base, 64);
    chk("ovf_q_empty", exp_cap.size(), 0);
    chk("ovf_txe_free", txe_n, 0);

    // Underrun leaves the command pointers alone.
    rd_n = 1'b0;
    tick();
    rd_n = 1'b1;
    chk("udr_err", err_underrun, 1);
    chk("udr_rxf", rxf_n, 1);
    load_cmd(32'hDEAD_BEEF);
    tick();
    read_word(32'hDEAD_BEEF);
    oe_n = 1'b1;
    tick();

    // Contention: write while master drives oe_n low is dropped.
    oe_n = 1'b0; wr_n = 1'b0; bus_din = 32'h0BAD_0BAD; be_din = 4'hF;
    tick();
    wr_n = 1'b1; oe_n = 1'b1;
    chk("con_err", err_contention, 1);
    chk("con_no_cap", cap_valid, 0);
    chk("con_ovf_sticky", err_overflow, 1);

    // Reset mid-transfer discards buffers and the pending pop.
    load_cmd(32'h1234_5678);
    load_cmd(32'h9ABC_DEF0);
    cap_ready = 1'b0;
    wr_n = 1'b0; bus_din = 32'h5555_AAAA;
    tick();
    wr_n = 1'b1;
    oe_n = 1'b0;
    tick();
    rd_n = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_txe_n", txe_n, 1);
    chk("mid_rxf_n", rxf_n, 1);
    chk("mid_bus_oe", bus_oe, 0);
    chk("mid_dout", {be_dout, bus_dout}, 0);
    chk("mid_cap_valid", cap_valid, 0);
    chk("mid_errs", {err_overflow, err_underrun, err_contention}, 0);
    rd_n = 1'b1; oe_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_txe_n", txe_n, 0);
    chk("post_rxf_n", rxf_n, 1);
    tick();
    chk("post_dout", {be_dout, bus_dout}, 0);
    chk("post_cap_valid", cap_valid, 0);
    chk("rd_q_empty", exp_rd.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
